// File: rtl/regfile_write_arbiter.sv
// Round-robin valid/ready arbiter for the single register-file write port; outputs registered, 1-cycle latency.
// Define REGFILE_INIT_CLEAR_EN to add a post-reset sweep that zeroes X0..ZERO_REG-1 (Busy=1, Ready held low).
module regfile_write_arbiter #(
   parameter int DATA_WIDTH = 64,
   parameter int ADDR_WIDTH = 5,
   parameter int ZERO_REG   = 31
) (
   input  logic                  Clk,
   input  logic                  Reset,
   input  logic                  Req0Valid,
   output logic                  Req0Ready,
   input  logic [ADDR_WIDTH-1:0] Req0RW,
   input  logic [DATA_WIDTH-1:0] Req0BusW,
   input  logic                  Req1Valid,
   output logic                  Req1Ready,
   input  logic [ADDR_WIDTH-1:0] Req1RW,
   input  logic [DATA_WIDTH-1:0] Req1BusW,
   output logic [ADDR_WIDTH-1:0] RW,
   output logic [DATA_WIDTH-1:0] BusW,
   output logic                  RegWr,
   output logic                  Busy,
   output logic                  Dropped
);

   localparam logic [ADDR_WIDTH-1:0] ZERO_IDX = ADDR_WIDTH'(ZERO_REG);

   logic                  ptr;
   logic                  run;
   logic                  grant0;
   logic                  grant1;
   logic                  accept;
   logic [ADDR_WIDTH-1:0] sel_rw;
   logic [DATA_WIDTH-1:0] sel_busw;

`ifdef REGFILE_INIT_CLEAR_EN
   typedef enum logic {ST_INIT, ST_RUN} state_t;
   state_t                state;
   logic [ADDR_WIDTH-1:0] init_cnt;

   assign run  = (state == ST_RUN);
   assign Busy = (state == ST_INIT);
`else
   assign run  = 1'b1;
   assign Busy = 1'b0;
`endif

   // ptr=0 favours requester 0 on a tie; a lone requester always wins
   always_comb begin
      grant0 = run && !Reset && Req0Valid && (!Req1Valid || !ptr);
      grant1 = run && !Reset && Req1Valid && (!Req0Valid || ptr);
   end

   assign Req0Ready = grant0;
   assign Req1Ready = grant1;
   assign accept    = grant0 || grant1;
   assign sel_rw    = grant1 ? Req1RW : Req0RW;
   assign sel_busw  = grant1 ? Req1BusW : Req0BusW;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         RegWr   <= 1'b0;
         RW      <= '0;
         BusW    <= '0;
         Dropped <= 1'b0;
         ptr     <= 1'b0;
`ifdef REGFILE_INIT_CLEAR_EN
         state    <= ST_INIT;
         init_cnt <= '0;
`endif
      end
`ifdef REGFILE_INIT_CLEAR_EN
      else if (state == ST_INIT) begin
         Dropped <= 1'b0;
         // counter reaching ZERO_IDX means the last sweep write is already on the port
         if (init_cnt == ZERO_IDX) begin
            RegWr <= 1'b0;
            state <= ST_RUN;
         end else begin
            RegWr    <= 1'b1;
            RW       <= init_cnt;
            BusW     <= '0;
            init_cnt <= init_cnt + ADDR_WIDTH'(1);
         end
      end
`endif
      else if (accept) begin
         RW      <= sel_rw;
         BusW    <= sel_busw;
         RegWr   <= (sel_rw != ZERO_IDX);
         Dropped <= (sel_rw == ZERO_IDX);
         ptr     <= grant0;
      end else begin
         RegWr   <= 1'b0;
         Dropped <= 1'b0;
      end
   end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter: expected writes queued at handshake, compared one cycle later.
// Covers both builds; the sweep checks are active when REGFILE_INIT_CLEAR_EN is defined.
module tb_regfile_write_arbiter;

   localparam int ZERO_REG = 31;
`ifdef REGFILE_INIT_CLEAR_EN
   localparam logic BUSY_RST = 1'b1;
`else
   localparam logic BUSY_RST = 1'b0;
`endif

   typedef struct {
      logic [4:0]  rw;
      logic [63:0] d;
   } wr_t;

   logic        clk;
   logic        reset;
   logic        req0_valid;
   logic        req0_ready;
   logic [4:0]  req0_rw;
   logic [63:0] req0_busw;
   logic        req1_valid;
   logic        req1_ready;
   logic [4:0]  req1_rw;
   logic [63:0] req1_busw;
   logic [4:0]  rw;
   logic [63:0] busw;
   logic        reg_wr;
   logic        busy;
   logic        dropped;

   int          n_checks = 0;
   int          n_errors = 0;
   logic        mon_en = 1'b0;
   logic        tb_ptr = 1'b0;
   wr_t         exp_q[$];
   wr_t         e;
   logic        e0;
   logic        e1;
   logic [63:0] rf [0:31];
   logic        a0;
   logic        a1;
   int          n_acc;
   logic [63:0] last0;
   logic [63:0] last1;
   logic [63:0] d7;

   regfile_write_arbiter dut (
      .Clk       (clk),
      .Reset     (reset),
      .Req0Valid (req0_valid),
      .Req0Ready (req0_ready),
      .Req0RW    (req0_rw),
      .Req0BusW  (req0_busw),
      .Req1Valid (req1_valid),
      .Req1Ready (req1_ready),
      .Req1RW    (req1_rw),
      .Req1BusW  (req1_busw),
      .RW        (rw),
      .BusW      (busw),
      .RegWr     (reg_wr),
      .Busy      (busy),
      .Dropped   (dropped)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // register file model writes on the falling edge, like the real one
   always @(negedge clk) begin
      if (reg_wr === 1'b1) rf[rw] <= busw;
   end

   // scoreboard: pop what was accepted last cycle, then predict this cycle's grant
   always @(negedge clk) begin
      if (mon_en) begin
         check("busy_run", 64'(busy), 64'(0));
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("wr_rw", 64'(rw), 64'(e.rw));
            check("wr_busw", busw, e.d);
            check("wr_regwr", 64'(reg_wr), 64'(e.rw != 5'(ZERO_REG)));
            check("wr_dropped", 64'(dropped), 64'(e.rw == 5'(ZERO_REG)));
         end else begin
            check("idle_regwr", 64'(reg_wr), 64'(0));
            check("idle_dropped", 64'(dropped), 64'(0));
         end
         e0 = req0_valid && (!req1_valid || !tb_ptr);
         e1 = req1_valid && (!req0_valid || tb_ptr);
         check("rdy0", 64'(req0_ready), 64'(e0));
         check("rdy1", 64'(req1_ready), 64'(e1));
         if (e0) begin
            exp_q.push_back('{rw: req0_rw, d: req0_busw});
            tb_ptr = 1'b1;
         end else if (e1) begin
            exp_q.push_back('{rw: req1_rw, d: req1_busw});
            tb_ptr = 1'b0;
         end
      end
   end

   task automatic apply_reset();
      mon_en = 1'b0;
      exp_q.delete();
      tb_ptr = 1'b0;
      @(posedge clk); #1 reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("rst_regwr", 64'(reg_wr), 64'(0));
      check("rst_rw", 64'(rw), 64'(0));
      check("rst_busw", busw, 64'(0));
      check("rst_dropped", 64'(dropped), 64'(0));
      check("rst_rdy0", 64'(req0_ready), 64'(0));
      check("rst_rdy1", 64'(req1_ready), 64'(0));
      check("rst_busy", 64'(busy), 64'(BUSY_RST));
      @(posedge clk); #1 reset = 1'b0;
   endtask

   // checks n sweep writes; a full sweep hands over to the scoreboard
   task automatic init_sweep(input int n);
`ifdef REGFILE_INIT_CLEAR_EN
      @(negedge clk);
      check("sweep_start_busy", 64'(busy), 64'(1));
      check("sweep_start_regwr", 64'(reg_wr), 64'(0));
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         check("sweep_regwr", 64'(reg_wr), 64'(1));
         check("sweep_rw", 64'(rw), 64'(i));
         check("sweep_busw", busw, 64'(0));
         check("sweep_busy", 64'(busy), 64'(1));
         check("sweep_rdy0", 64'(req0_ready), 64'(0));
      end
      if (n == 31) begin
         @(posedge clk); #1;
      end
`endif
      if (n == 31) mon_en = 1'b1;
   endtask

   task automatic send(input logic port, input logic [4:0] a, input logic [63:0] d);
      logic done;
      done = 1'b0;
      if (!port) begin
         req0_valid = 1'b1; req0_rw = a; req0_busw = d;
      end else begin
         req1_valid = 1'b1; req1_rw = a; req1_busw = d;
      end
      for (int c = 0; c < 40 && !done; c++) begin
         @(negedge clk);
         done = port ? req1_ready : req0_ready;
      end
      check("send_accepted", 64'(done), 64'(1));
      @(posedge clk); #1;
      if (!port) req0_valid = 1'b0;
      else       req1_valid = 1'b0;
   endtask

   task automatic settle();
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial begin
      for (int i = 0; i < 31; i++) rf[i] = 64'hA5A5_A5A5_A5A5_A5A5;
      rf[31] = '0;
      reset = 1'b1;
      req0_valid = 1'b0; req0_rw = '0; req0_busw = '0;
      req1_valid = 1'b0; req1_rw = '0; req1_busw = '0;

      // request already pending when reset releases
      req0_valid = 1'b1; req0_rw = 5'd5; req0_busw = 64'hDEAD_BEEF;
      apply_reset();
      init_sweep(31);
      send(1'b0, 5'd5, 64'hDEAD_BEEF);
      settle();
      check("rf_x5", rf[5], 64'hDEAD_BEEF);

      send(1'b1, 5'd31, 64'h1);
      settle();
      check("rf_x31_zero", rf[31], 64'h0);
      check("rf_x5_kept", rf[5], 64'hDEAD_BEEF);

      // both requesters held: grants must alternate starting with requester 0
      req0_rw = 5'd1; req0_busw = {$urandom, $urandom}; req0_valid = 1'b1;
      req1_rw = 5'd2; req1_busw = {$urandom, $urandom}; req1_valid = 1'b1;
      n_acc = 0;
      last0 = '0;
      last1 = '0;
      for (int c = 0; c < 30 && (req0_valid || req1_valid); c++) begin
         @(negedge clk);
         a0 = req0_ready;
         a1 = req1_ready;
         if (a0 || a1) begin
            if (n_acc < 4) check("alt_grant", 64'(a1), 64'(n_acc % 2));
            n_acc++;
         end
         @(posedge clk); #1;
         if (a0) begin
            last0 = req0_busw;
            if (n_acc < 4) req0_busw = {$urandom, $urandom};
            else           req0_valid = 1'b0;
         end
         if (a1) begin
            last1 = req1_busw;
            if (n_acc < 4) req1_busw = {$urandom, $urandom};
            else           req1_valid = 1'b0;
         end
      end
      check("both_drained", 64'(req0_valid || req1_valid), 64'(0));
      settle();
      check("rf_x1", rf[1], last0);
      check("rf_x2", rf[2], last1);

      // reset with a write in flight, then restart
      d7 = {$urandom, $urandom};
      req0_valid = 1'b1; req0_rw = 5'd7; req0_busw = d7;
      apply_reset();
`ifdef REGFILE_INIT_CLEAR_EN
      init_sweep(10);
      apply_reset();
`endif
      init_sweep(31);
`ifdef REGFILE_INIT_CLEAR_EN
      for (int i = 0; i < 31; i++) check("rf_cleared", rf[i], 64'h0);
`endif
      send(1'b0, 5'd7, d7);
      settle();
      check("rf_x7", rf[7], d7);

      mon_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the single register-file write port (RW/BusW/RegWr) between two writeback requesters, e.g. ALU result and memory load.
- Uses a valid/ready handshake with round-robin arbitration.
- Outputs are registered on posedge Clk, so they are stable across the register file's negedge write.
- Optionally runs a post-reset sweep that zeroes X0..X30 through the same port.

Parameters:
- DATA_WIDTH, 64, width of BusW and request data
- ADDR_WIDTH, 5, register index width
- ZERO_REG, 31, hard-wired zero register index; writes to it are dropped

Ports:
- Clk  input  1  clock; all state updates on posedge
- Reset  input  1  synchronous, active-high reset
- Req0Valid  input  1  requester 0 has a write pending
- Req0Ready  output  1  requester 0 write accepted this cycle when Valid&&Ready
- Req0RW  input  ADDR_WIDTH  requester 0 destination register
- Req0BusW  input  DATA_WIDTH  requester 0 write data
- Req1Valid  input  1  requester 1 has a write pending
- Req1Ready  output  1  requester 1 accept
- Req1RW  input  ADDR_WIDTH  requester 1 destination register
- Req1BusW  input  DATA_WIDTH  requester 1 write data
- RW  output  ADDR_WIDTH  to register file write index
- BusW  output  DATA_WIDTH  to register file write data
- RegWr  output  1  to register file write enable
- Busy  output  1  init sweep in progress
- Dropped  output  1  one-cycle pulse: accepted write targeted ZERO_REG

Behaviour:
- Clock and reset: single clock Clk; Reset is synchronous and active-high, sampled on posedge Clk.
- Reset values:
  - RegWr=0, RW=0, BusW=0, Dropped=0.
  - Round-robin pointer set to favour requester 0.
  - Init counter=0.
  - State = INIT if the macro is defined, else RUN.
- While Reset=1: Req0Ready=Req1Ready=0.
- States:
  - INIT: one write per cycle, RegWr=1, RW=counter, BusW=0. Counter runs 0..ZERO_REG-1 (31 writes).
  - INIT -> RUN: after the write to index ZERO_REG-1 is driven.
  - Busy=1 throughout INIT. Both Ready outputs are 0 in INIT.
  - RUN: arbitration; no exit except Reset.
- Ready generation (RUN, combinational from Valid inputs and pointer):
  - Only one requester Valid: it gets Ready=1.
  - Both Valid: the requester the pointer favours gets Ready=1; the other gets 0.
  - At most one Ready high per cycle. Ready never asserts without matching Valid.
- Pointer update: after any accept, the pointer favours the other requester. With no accept, the pointer holds.
- Requester obligation: Valid, RW and BusW held stable until accepted; Valid must not depend on Ready.
- Latency:
  - Accepted request (posedge N) drives RW/BusW on outputs from posedge N+1 for exactly one cycle.
  - RegWr=1 for that cycle unless RW==ZERO_REG.
  - Throughput: 1 write per cycle; back-to-back accepts give consecutive one-cycle RegWr pulses.
- Accepted RW==ZERO_REG:
  - Handshake completes normally.
  - Next cycle: RegWr=0, Dropped=1 for one cycle; RW/BusW still reflect the request.
- No accept in a cycle: next cycle RegWr=0 and Dropped=0; RW/BusW hold their last value.
- Reset mid-INIT or mid-RUN:
  - Next cycle outputs take reset values; any in-flight registered write is cancelled (RegWr=0).
  - INIT restarts from counter 0.
- Starvation: with both Valid continuously, grants strictly alternate 0,1,0,1.

Optional Feature:
- REGFILE_INIT_CLEAR_EN defined:
  - INIT state and counter compiled in.
  - Every reset is followed by a 31-cycle zeroing sweep with Busy=1; first Ready possible at cycle 32 after Reset deasserts.
- Not defined:
  - No INIT state; Busy tied 0.
  - Arbitration starts the first cycle after Reset deasserts.

Test Plan:
- Macro on, Reset 1 cycle then low -> RegWr=1 for 31 consecutive cycles with RW=0..30, BusW=0, Busy=1; then Busy=0; Ready rises the next cycle Req0Valid=1.
- Req0Valid=1, Req0RW=5, Req0BusW=64'hDEAD_BEEF, Req1Valid=0 -> Req0Ready=1; next cycle RW=5, BusW=64'hDEADBEEF, RegWr=1; a register file model reads X5=64'hDEADBEEF.
- Both Valid held for 4 accepts (Req0RW=1, Req1RW=2, new data each accept) -> grants 0,1,0,1; RegWr high 4 consecutive cycles; RW sequence 1,2,1,2.
- Req1Valid=1, Req1RW=31, Req1BusW=64'h1 -> Req1Ready=1; next cycle RegWr=0, Dropped=1; register file X31 still reads 0.
- Macro on, Reset pulsed at init count 10 -> RegWr=0 the cycle after; sweep restarts at RW=0; full 31 writes complete.
- Macro off, Reset then Req0Valid=1 in the first post-reset cycle -> Req0Ready=1 immediately; Busy stays 0 throughout.
